// File: rtl/seg_display_arbiter_pkg.sv
// Shared definitions for the 7-segment display arbiter.
// Holds the active-low SEG character codes, the active-low anode encodings,
// the arbiter state encoding and small helpers for round-robin selection.
package seg_display_arbiter_pkg;

  // Active-low segment codes, bit 7 = decimal point (off), bits 6:0 = g..a.
  localparam logic [7:0] SegCode0  = 8'hC0;
  localparam logic [7:0] SegCode1  = 8'hF9;
  localparam logic [7:0] SegCode2  = 8'hA4;
  localparam logic [7:0] SegCode3  = 8'hB0;
  localparam logic [7:0] SegCode4  = 8'h99;
  localparam logic [7:0] SegCode5  = 8'h92;
  localparam logic [7:0] SegCode6  = 8'h82;
  localparam logic [7:0] SegCode7  = 8'hF8;
  localparam logic [7:0] SegCode8  = 8'h80;
  localparam logic [7:0] SegCode9  = 8'h90;
  localparam logic [7:0] SegCodeL  = 8'hC7;
  localparam logic [7:0] SegCodeH  = 8'h89;
  localparam logic [7:0] SegBlank  = 8'hFF;

  // Active-low one-hot anode selects.
  localparam logic [3:0] An3   = 4'b0111;
  localparam logic [3:0] An2   = 4'b1011;
  localparam logic [3:0] An1   = 4'b1101;
  localparam logic [3:0] An0   = 4'b1110;
  localparam logic [3:0] AnOff = 4'b1111;

  // Digit index: 3 = AN3 (leftmost, first in a frame) down to 0 = AN0.
  typedef logic [1:0] digit_t;
  localparam digit_t DigAn3 = 2'd3;

  typedef enum logic {StBlank, StShow} state_e;

  function automatic logic [3:0] an_onehot(input digit_t d);
    logic [3:0] an;
    unique case (d)
      2'd3: an = An3;
      2'd2: an = An2;
      2'd1: an = An1;
      2'd0: an = An0;
    endcase
    return an;
  endfunction

  // Source indices live in 0..2, so wrap explicitly rather than mod 4.
  function automatic logic [1:0] inc_mod3(input logic [1:0] v);
    return (v == 2'd2) ? 2'd0 : v + 2'd1;
  endfunction

  // First set bit of req scanning upward from ptr with wrap-around.
  function automatic logic [1:0] rr_pick(input logic [2:0] req, input logic [1:0] ptr);
    logic [1:0] idx;
    logic [1:0] pick;
    logic       found;
    idx   = ptr;
    pick  = 2'd0;
    found = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (!found && req[idx]) begin
        pick  = idx;
        found = 1'b1;
      end
      idx = inc_mod3(idx);
    end
    return pick;
  endfunction

endpackage

// File: rtl/seg_display_arbiter_if.sv
// Bus between the display arbiter and its sources / display pins.
//   req        : per-source request, bit i = source i
//   chars0..2  : per-source characters, active-low SEG, [31:24] = AN3 ... [7:0] = AN0
//   force_en   : override arbitration with force_src (3 = blank)
//   final_AN   : active-low anode select
//   final_SEG  : active-low segment pattern
//   grant      : one-hot current owner, 000 when blank
//   frame_tick : one-cycle pulse on the first cycle of each frame
// slave = arbiter side, master = driver of requests / observer of display.
interface seg_display_arbiter_if;
  logic [2:0]  req;
  logic [31:0] chars0;
  logic [31:0] chars1;
  logic [31:0] chars2;
  logic        force_en;
  logic [1:0]  force_src;
  logic [3:0]  final_AN;
  logic [7:0]  final_SEG;
  logic [2:0]  grant;
  logic        frame_tick;

  modport master (
    output req, chars0, chars1, chars2, force_en, force_src,
    input  final_AN, final_SEG, grant, frame_tick
  );

  modport slave (
    input  req, chars0, chars1, chars2, force_en, force_src,
    output final_AN, final_SEG, grant, frame_tick
  );
endinterface

// File: rtl/seg_display_arbiter_scan_timer.sv
// seg_scan_timer: slot / digit timing for the multiplexed display.
//   clk, reset : system clock, asynchronous active-high reset
//   digit      : current digit index (3 = AN3 ... 0 = AN0)
//   in_blank   : high during the first BLANK_CYC cycles of each slot
//   frame_tick : high on slot 0 of digit AN3 (frame boundary)
module seg_scan_timer
  import seg_display_arbiter_pkg::*;
#(
  parameter int unsigned SCAN_DIV  = 35714,
  parameter int unsigned BLANK_CYC = 64
) (
  input  logic   clk,
  input  logic   reset,
  output digit_t digit,
  output logic   in_blank,
  output logic   frame_tick
);

  localparam int unsigned CntW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CntW-1:0] CntMax = CntW'(SCAN_DIV - 1);

  logic [CntW-1:0] slot_q;
  digit_t          digit_q;
  logic            run_q;

  // run_q holds the counter at the AN3/slot 0 position for the first cycle out of
  // reset, so the first frame boundary is seen on the first clk after deassertion.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      slot_q  <= '0;
      digit_q <= DigAn3;
      run_q   <= 1'b0;
    end else begin
      run_q <= 1'b1;
      if (run_q) begin
        if (slot_q == CntMax) begin
          slot_q  <= '0;
          digit_q <= digit_q - 2'd1;  // 3->2->1->0->3 by natural wrap
        end else begin
          slot_q <= slot_q + CntW'(1);
        end
      end
    end
  end

  assign digit      = digit_q;
  assign in_blank   = (32'(slot_q) < BLANK_CYC);
  assign frame_tick = run_q && (slot_q == '0) && (digit_q == DigAn3);

endmodule

// File: rtl/seg_display_arbiter.sv
// seg_display_arbiter: shares one 4-digit multiplexed 7-segment display between
// three sources with frame-aligned round-robin arbitration, a minimum hold time,
// a force override and tear-free character snapshots.
//   clk, reset : system clock, asynchronous active-high reset
//   bus        : seg_display_arbiter_if.slave (requests, characters, force, display)
module seg_display_arbiter
  import seg_display_arbiter_pkg::*;
#(
  parameter int unsigned SCAN_DIV    = 35714,
  parameter int unsigned BLANK_CYC   = 64,
  parameter int unsigned HOLD_FRAMES = 140
) (
  input logic                  clk,
  input logic                  reset,
  seg_display_arbiter_if.slave bus
);

  localparam int unsigned HoldW = (HOLD_FRAMES > 0) ? $clog2(HOLD_FRAMES + 1) : 1;
  localparam logic [HoldW-1:0] HoldMax = HoldW'(HOLD_FRAMES);

  digit_t digit;
  logic   in_blank;
  logic   tick;

  seg_scan_timer #(
    .SCAN_DIV  (SCAN_DIV),
    .BLANK_CYC (BLANK_CYC)
  ) u_scan_timer (
    .clk        (clk),
    .reset      (reset),
    .digit      (digit),
    .in_blank   (in_blank),
    .frame_tick (tick)
  );

  state_e           state_q, state_d;
  logic [1:0]       owner_q, owner_d;
  logic [1:0]       rr_q, rr_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic [31:0]      snap_q, snap_d;
  logic [3:0]       an_q, an_d;
  logic [7:0]       seg_q, seg_d;
  logic [2:0]       grant_q, grant_d;

  logic [2:0]       others;
  logic [1:0]       pick_any;
  logic [1:0]       pick_oth;
  logic [HoldW-1:0] frames_done;
  logic [31:0]      owner_chars;
  logic [7:0]       cur_byte;

  // Arbitration candidates for this boundary.
  always_comb begin
    others      = bus.req & ~(3'b001 << owner_q);
    pick_any    = rr_pick(bus.req, rr_q);
    pick_oth    = rr_pick(others, rr_q);
    // Frames the owner will have shown once the current frame ends, saturating.
    frames_done = (hold_q >= HoldMax) ? HoldMax : hold_q + HoldW'(1);
  end

  // Owner decision; only a frame boundary may change anything. A simultaneous
  // owner release and new request collapse into the single pick_any decision.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    rr_d    = rr_q;
    hold_d  = hold_q;
    if (tick) begin
      if (bus.force_en) begin
        hold_d = '0;
        if (bus.force_src == 2'd3) begin
          state_d = StBlank;
        end else begin
          state_d = StShow;
          owner_d = bus.force_src;
          rr_d    = inc_mod3(bus.force_src);
        end
      end else if (state_q == StBlank) begin
        if (|bus.req) begin
          state_d = StShow;
          owner_d = pick_any;
          rr_d    = inc_mod3(pick_any);
          hold_d  = '0;
        end
      end else if (!bus.req[owner_q]) begin
        hold_d = '0;
        if (|bus.req) begin
          owner_d = pick_any;
          rr_d    = inc_mod3(pick_any);
        end else begin
          state_d = StBlank;
        end
      end else if ((frames_done >= HoldMax) && (|others)) begin
        owner_d = pick_oth;
        rr_d    = inc_mod3(pick_oth);
        hold_d  = '0;
      end else begin
        hold_d = frames_done;
      end
    end
  end

  // Snapshot and next display values.
  always_comb begin
    unique case (owner_d)
      2'd0:    owner_chars = bus.chars0;
      2'd1:    owner_chars = bus.chars1;
      default: owner_chars = bus.chars2;
    endcase

    snap_d = snap_q;
    if (tick) begin
      snap_d = (state_d == StShow) ? owner_chars : 32'hFFFF_FFFF;
    end

    unique case (digit)
      2'd3: cur_byte = snap_d[31:24];
      2'd2: cur_byte = snap_d[23:16];
      2'd1: cur_byte = snap_d[15:8];
      2'd0: cur_byte = snap_d[7:0];
    endcase

    if (state_d == StBlank) begin
      an_d    = AnOff;
      seg_d   = SegBlank;
      grant_d = 3'b000;
    end else begin
      an_d    = in_blank ? AnOff : an_onehot(digit);
      seg_d   = cur_byte;
      grant_d = 3'b001 << owner_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= StBlank;
      owner_q <= 2'd0;
      rr_q    <= 2'd0;
      hold_q  <= '0;
      snap_q  <= 32'hFFFF_FFFF;
      an_q    <= AnOff;
      seg_q   <= SegBlank;
      grant_q <= 3'b000;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      rr_q    <= rr_d;
      hold_q  <= hold_d;
      snap_q  <= snap_d;
      an_q    <= an_d;
      seg_q   <= seg_d;
      grant_q <= grant_d;
    end
  end

  assign bus.final_AN   = an_q;
  assign bus.final_SEG  = seg_q;
  assign bus.grant      = grant_q;
  assign bus.frame_tick = tick;

endmodule

// File: tb/tb_seg_display_arbiter.sv
// Self-checking bench for seg_display_arbiter with a frame-level reference model.
module tb_seg_display_arbiter;

  localparam int SCAN  = 8;
  localparam int BLANK = 2;
  localparam int HOLD  = 2;
  localparam int FRAME = 4 * SCAN;

  logic clk = 1'b0;
  logic reset = 1'b0;

  seg_display_arbiter_if dif ();

  seg_display_arbiter #(
    .SCAN_DIV    (SCAN),
    .BLANK_CYC   (BLANK),
    .HOLD_FRAMES (HOLD)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (dif.slave)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int t       = 0;  // posedges since reset release

  // Reference model: owner (-1 = blank), frames shown by owner, round-robin pointer.
  int          m_owner;
  int          m_frames;
  int          m_rr;
  logic [31:0] m_snap;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, t);
    end
  endtask

  function automatic int pick(input int from, input logic [2:0] r);
    for (int i = 0; i < 3; i++) begin
      if (r[(from + i) % 3]) return (from + i) % 3;
    end
    return -1;
  endfunction

  function automatic logic [31:0] chars_of(input int s);
    if (s == 0) return dif.chars0;
    if (s == 1) return dif.chars1;
    return dif.chars2;
  endfunction

  task automatic model_init();
    m_owner  = -1;
    m_frames = 0;
    m_rr     = 0;
    m_snap   = 32'hFFFF_FFFF;
    t        = 0;
  endtask

  task automatic give(input int w);
    m_owner  = w;
    m_frames = 0;
    m_rr     = (w + 1) % 3;
  endtask

  task automatic model_boundary();
    logic [2:0] oth;
    if (dif.force_en) begin
      if (dif.force_src == 2'd3) m_owner = -1;
      else give(int'(dif.force_src));
      m_frames = 0;
    end else if (m_owner < 0) begin
      if (dif.req != 3'b000) give(pick(m_rr, dif.req));
    end else if (!dif.req[m_owner]) begin
      if (dif.req != 3'b000) give(pick(m_rr, dif.req));
      else begin
        m_owner  = -1;
        m_frames = 0;
      end
    end else begin
      m_frames = (m_frames + 1 > HOLD) ? HOLD : m_frames + 1;
      oth = dif.req;
      oth[m_owner] = 1'b0;
      if (m_frames >= HOLD && oth != 3'b000) give(pick(m_rr, oth));
    end
    m_snap = (m_owner < 0) ? 32'hFFFF_FFFF : chars_of(m_owner);
  endtask

  // One clock: sample outputs on the falling edge and compare to the model.
  task automatic step();
    int q, slot, dig;
    logic [3:0] e_an;
    logic [7:0] e_seg;
    logic [2:0] e_gnt;
    @(negedge clk);
    t++;
    if (t >= 2 && ((t - 2) % FRAME) == 0) model_boundary();
    e_an  = 4'b1111;
    e_seg = 8'hFF;
    e_gnt = 3'b000;
    if (t >= 2 && m_owner >= 0) begin
      q     = (t - 2) % FRAME;
      slot  = q % SCAN;
      dig   = 3 - q / SCAN;
      e_seg = m_snap[8*dig +: 8];
      e_an  = (slot < BLANK) ? 4'b1111 : ~(4'b0001 << dig);
      e_gnt = 3'(1 << m_owner);
    end
    check("frame_tick", 32'(dif.frame_tick), 32'(((t - 1) % FRAME) == 0));
    check("final_AN", 32'(dif.final_AN), 32'(e_an));
    check("final_SEG", 32'(dif.final_SEG), 32'(e_seg));
    check("grant", 32'(dif.grant), 32'(e_gnt));
  endtask

  task automatic apply_reset();
    reset = 1'b1;
    #1;
    check("rst_AN", 32'(dif.final_AN), 32'h0000_000F);
    check("rst_SEG", 32'(dif.final_SEG), 32'h0000_00FF);
    check("rst_grant", 32'(dif.grant), 32'h0);
    check("rst_tick", 32'(dif.frame_tick), 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b0;
    model_init();
  endtask

  task automatic random_cycles(input int n);
    for (int c = 0; c < n; c++) begin
      step();
      if ($urandom_range(0, 7) == 0) dif.chars0 = $urandom();
      if ($urandom_range(0, 7) == 0) dif.chars1 = $urandom();
      if ($urandom_range(0, 7) == 0) dif.chars2 = $urandom();
      if ($urandom_range(0, 47) == 0) dif.req = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 199) == 0) begin
        dif.force_en  = ~dif.force_en;
        dif.force_src = 2'($urandom_range(0, 3));
      end
    end
  endtask

  initial begin
    dif.req       = 3'b000;
    dif.chars0    = 32'hFFFF_FFFF;
    dif.chars1    = $urandom();
    dif.chars2    = $urandom();
    dif.force_en  = 1'b0;
    dif.force_src = 2'd0;
    #3;
    apply_reset();

    // Idle: blank display, frame_tick every FRAME cycles.
    repeat (10 * FRAME) step();

    // Single requester with known characters.
    dif.req    = 3'b001;
    dif.chars0 = 32'hC0F9_A4B0;
    repeat (4 * FRAME) step();

    // All requesting: rotation every HOLD frames.
    dif.req = 3'b111;
    repeat (8 * FRAME) step();

    // Mid-frame character changes must wait for the next boundary.
    dif.req = 3'b001;
    for (int f = 0; f < 4; f++) begin
      for (int c = 0; c < FRAME; c++) begin
        step();
        if (c == 13) dif.chars0 = $urandom();
      end
    end

    // Force override, force to blank, release.
    dif.force_en  = 1'b1;
    dif.force_src = 2'd2;
    repeat (3 * FRAME) step();
    dif.force_src = 2'd3;
    repeat (2 * FRAME) step();
    dif.force_en = 1'b0;
    repeat (3 * FRAME) step();

    random_cycles(60 * FRAME);

    // Reset mid-slot while showing.
    dif.force_en = 1'b0;
    dif.req      = 3'b010;
    repeat (FRAME + 11) step();
    check("pre_rst_grant", 32'(dif.grant), 32'h2);
    #2;
    apply_reset();
    random_cycles(6 * FRAME);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
